// File: rtl/silu_poly_eval.sv
// SiLU polynomial evaluator: takes x, fetches (a, b, c) from the coefficient lookup and
// computes y = (a*x + b)*x + c in Horner form with one shared FP multiplier and one FP adder.
module silu_poly_eval #(
    parameter int BW_EXP = 8,
    parameter int BW_MAN = 8,
    parameter int BW_FP  = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BW_FP-1:0] in_x,
    output logic [BW_FP-1:0] coe_x,
    input  logic [BW_FP-1:0] coe_a,
    input  logic [BW_FP-1:0] coe_b,
    input  logic [BW_FP-1:0] coe_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BW_FP-1:0] out_y
);

    localparam int Ew = BW_EXP + 2;
    localparam logic [BW_EXP-1:0] ExpZero = {1'b1, {(BW_EXP-1){1'b0}}};
    localparam logic [BW_EXP-1:0] ExpMax  = {1'b0, {(BW_EXP-1){1'b1}}};
    localparam logic signed [Ew-1:0] EMax = {{(Ew-BW_EXP){1'b0}}, ExpMax};
    localparam logic signed [Ew-1:0] EMin = -EMax;
    localparam logic [BW_FP-1:0] Zero = {ExpZero, {(BW_MAN+1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StLook, StMul1, StAdd1, StMul2, StAdd2, StDone} state_t;

    state_t           state_q;
    logic [BW_FP-1:0] x_q, a_q, b_q, c_q, t_q, y_q;
    logic [BW_FP-1:0] mul_a, mul_res, add_b, add_res;

    function automatic logic is_zero(input logic [BW_FP-1:0] w);
        return w[BW_FP-1 -: BW_EXP] == ExpZero;
    endfunction

    function automatic logic signed [Ew-1:0] exp_of(input logic [BW_FP-1:0] w);
        return {{(Ew-BW_EXP){w[BW_FP-1]}}, w[BW_FP-1 -: BW_EXP]};
    endfunction

    function automatic logic [BW_FP-1:0] fp_mul(input logic [BW_FP-1:0] p,
                                                 input logic [BW_FP-1:0] q);
        logic                  s;
        logic signed [Ew-1:0]  e;
        logic [2*BW_MAN+1:0]   m;
        logic [BW_MAN-1:0]     man;
        logic [BW_FP-1:0]      res;
        s = p[BW_MAN] ^ q[BW_MAN];
        e = exp_of(p) + exp_of(q);
        m = {1'b1, p[BW_MAN-1:0]} * {1'b1, q[BW_MAN-1:0]};
        if (m[2*BW_MAN+1]) begin
            man = m[2*BW_MAN -: BW_MAN];
            e   = e + Ew'(1);
        end else begin
            man = m[2*BW_MAN-1 -: BW_MAN];
        end
        if (is_zero(p) || is_zero(q)) res = Zero;
        else if (e > EMax)            res = {ExpMax, s, {BW_MAN{1'b1}}};
        else if (e < EMin)            res = Zero;
        else                          res = {e[BW_EXP-1:0], s, man};
        return res;
    endfunction

    function automatic logic [BW_FP-1:0] fp_add(input logic [BW_FP-1:0] p,
                                                 input logic [BW_FP-1:0] q);
        logic                 swap, found;
        logic [BW_FP-1:0]     big, sml, res;
        logic signed [Ew-1:0] eb, e;
        logic [Ew-1:0]        d;
        logic [BW_MAN:0]      mb, ms, diff;
        logic [BW_MAN+1:0]    sum;
        int                   lz;
        swap = (exp_of(q) > exp_of(p)) ||
               ((exp_of(q) == exp_of(p)) && (q[BW_MAN-1:0] > p[BW_MAN-1:0]));
        big  = swap ? q : p;
        sml  = swap ? p : q;
        eb   = exp_of(big);
        d    = eb - exp_of(sml);
        mb   = {1'b1, big[BW_MAN-1:0]};
        ms   = {1'b1, sml[BW_MAN-1:0]} >> d;
        sum  = {1'b0, mb} + {1'b0, ms};
        diff = mb - ms;
        lz    = 0;
        found = 1'b0;
        for (int i = BW_MAN; i >= 0; i--) begin
            if (!found) begin
                if (diff[i]) found = 1'b1;
                else         lz = lz + 1;
            end
        end
        res = big;
        if (is_zero(p)) begin
            res = q;
        end else if (is_zero(q)) begin
            res = p;
        end else if (d > Ew'(BW_MAN + 1)) begin
            res = big;
        end else if (p[BW_MAN] == q[BW_MAN]) begin
            if (sum[BW_MAN+1]) e = eb + Ew'(1);
            else               e = eb;
            if (e > EMax)            res = {ExpMax, big[BW_MAN], {BW_MAN{1'b1}}};
            else if (sum[BW_MAN+1])  res = {e[BW_EXP-1:0], big[BW_MAN], sum[BW_MAN:1]};
            else                     res = {e[BW_EXP-1:0], big[BW_MAN], sum[BW_MAN-1:0]};
        end else begin
            diff = diff << lz;
            e    = eb - Ew'(lz);
            if (!found || e < EMin) res = Zero;
            else                    res = {e[BW_EXP-1:0], big[BW_MAN], diff[BW_MAN-1:0]};
        end
        return res;
    endfunction

    // Operand muxes so a single multiplier and a single adder serve both Horner steps.
    always_comb begin
        mul_a   = (state_q == StMul1) ? a_q : t_q;
        add_b   = (state_q == StAdd1) ? b_q : c_q;
        mul_res = fp_mul(mul_a, x_q);
        add_res = fp_add(t_q, add_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= Zero;
            a_q     <= Zero;
            b_q     <= Zero;
            c_q     <= Zero;
            t_q     <= Zero;
            y_q     <= Zero;
        end else begin
            case (state_q)
                StIdle: if (in_valid) begin
                    x_q     <= in_x;
                    state_q <= StLook;
                end
                StLook: begin
                    a_q     <= coe_a;
                    b_q     <= coe_b;
                    c_q     <= coe_c;
                    state_q <= StMul1;
                end
                StMul1: begin
                    t_q     <= mul_res;
                    state_q <= StAdd1;
                end
                StAdd1: begin
                    t_q     <= add_res;
                    state_q <= StMul2;
                end
                StMul2: begin
                    t_q     <= mul_res;
                    state_q <= StAdd2;
                end
                StAdd2: begin
                    y_q     <= add_res;
                    state_q <= StDone;
                end
                StDone: if (out_ready) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_y     = y_q;
    assign coe_x     = x_q;

endmodule

// File: tb/tb_silu_poly_eval.sv
// Scoreboard bench for silu_poly_eval: directed vectors push expected y, a negedge monitor
// pops and compares on every out_valid && out_ready handshake.
module tb_silu_poly_eval;

    localparam logic [16:0] ZERO = 17'h10000;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [16:0] in_x, coe_x, coe_a, coe_b, coe_c, out_y;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    silu_poly_eval #(.BW_EXP(8), .BW_MAN(8), .BW_FP(17)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .coe_x     (coe_x),
        .coe_a     (coe_a),
        .coe_b     (coe_b),
        .coe_c     (coe_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    task automatic chk(input string name, input logic [16:0] act, input logic [16:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every accepted result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %h, expected no result", out_y);
            end else begin
                chk("out_y", out_y, exp_q.pop_front());
            end
        end
    end

    task automatic run_vec(input logic [16:0] x, input logic [16:0] a, input logic [16:0] b,
                           input logic [16:0] c, input logic [16:0] y, input int stall);
        int w;
        int cyc;
        coe_a     = a;
        coe_b     = b;
        coe_c     = c;
        out_ready = (stall == 0);
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_idle", {16'b0, in_ready}, 17'd1);
        in_x     = x;
        in_valid = 1'b1;
        exp_q.push_back(y);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("coe_x_look", coe_x, x);
        // cyc numbers the cycle the DUT is in; the accept cycle is cycle 0.
        cyc = 1;
        while (!out_valid && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 17'(cyc), 17'd6);
        for (int i = 0; i < stall; i++) begin
            chk("hold_out_y", out_y, y);
            chk("hold_in_ready", {16'b0, in_ready}, 17'd0);
            chk("hold_out_valid", {16'b0, out_valid}, 17'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after", {16'b0, in_ready}, 17'd1);
    endtask

    initial begin
        int w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_x      = ZERO;
        coe_a     = ZERO;
        coe_b     = ZERO;
        coe_c     = ZERO;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", {16'b0, out_valid}, 17'd0);
        chk("rst_in_ready", {16'b0, in_ready}, 17'd1);
        chk("rst_out_y", out_y, ZERO);
        chk("rst_coe_x", coe_x, ZERO);

        // x, a, b, c, expected y, stall cycles in DONE
        run_vec(17'h00200, 17'h00000, 17'h00000, 17'h00000, 17'h004C0, 0); // 2.0 -> 7.0
        run_vec(17'h00000, 17'h00000, 17'h00100, 17'h00000, 17'h00000, 0); // cancel -> 1.0
        run_vec(17'h00080, ZERO,      ZERO,      ZERO,      ZERO,      0); // all zero
        run_vec(17'h0FE00, 17'h00000, ZERO,      ZERO,      17'h0FEFF, 0); // saturate
        run_vec(17'h00280, 17'h1FE00, 17'h00100, 17'h1FC00, 17'h000C0, 0); // 3.0 -> 1.75
        run_vec(17'h00200, 17'h00000, 17'h00000, 17'h00000, 17'h004C0, 3); // stalled output
        run_vec(17'h00280, 17'h1FE00, 17'h00100, 17'h1FC00, 17'h000C0, 0); // back-to-back

        // Abort in MUL2: nothing is queued, so any later output is flagged by the monitor.
        coe_a    = 17'h00000;
        coe_b    = 17'h00000;
        coe_c    = 17'h00000;
        in_x     = 17'h00200;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", {16'b0, out_valid}, 17'd0);
        chk("abort_out_y", out_y, ZERO);
        chk("abort_coe_x", coe_x, ZERO);
        chk("abort_in_ready", {16'b0, in_ready}, 17'd1);
        repeat (10) @(posedge clk);
        #1;

        run_vec(17'h00200, 17'h00000, 17'h00000, 17'h00000, 17'h004C0, 0); // after abort

        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("queue_drained", 17'(exp_q.size()), 17'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
